// File: rtl/load_writeback.sv
// load_writeback
//   Memory-load writeback stage that drives the register file's M write port.
//   It takes one load request, issues one word read to data memory and waits for
//   the response. It then presents the destination register ID and the loaded data
//   for exactly one cycle. At all other times o_dstM is 4'hF, which means "no write".
//   Only one load is in flight at a time. Misaligned addresses, illegal destination
//   IDs and memory timeouts abort the request with a one-cycle error pulse.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    load request present
//   o_req_ready    idle; a request is accepted on i_req_valid && o_req_ready
//   i_req_addr     byte address of the word to load
//   i_req_dst      destination register ID (legal 0..5)
//   o_mem_rd_en    one-cycle read strobe to data memory
//   o_mem_addr     read address, valid while o_mem_rd_en is high
//   i_mem_rdata    read data, sampled only while waiting with i_mem_rvalid high
//   i_mem_rvalid   read response valid
//   o_dstM         register file write ID, 4'hF = no write
//   o_valM         register file write data (holds its last value)
//   o_done         one-cycle pulse alongside a real o_dstM write
//   o_err          one-cycle pulse on an aborted request
//   o_err_code     01 misaligned, 10 bad dst, 11 timeout; held until the next error

module load_writeback #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [3:0]        i_req_dst,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic [3:0]        o_dstM,
  output logic [DATA_W-1:0] o_valM,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam logic [3:0] NO_WRITE = 4'hF;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t            r_state,     w_stateNext;
  logic              r_reqReady,  w_reqReady;
  logic              r_memRdEn,   w_memRdEn;
  logic [ADDR_W-1:0] r_memAddr,   w_memAddr;
  logic [3:0]        r_dst,       w_dst;
  logic [3:0]        r_dstM,      w_dstM;
  logic [DATA_W-1:0] r_valM,      w_valM;
  logic              r_done,      w_done;
  logic              r_err,       w_err;
  logic [1:0]        r_errCode,   w_errCode;
  logic [7:0]        r_waitCnt,   w_waitCnt;

  // State and every output are registered so the register file sees clean,
  // glitch-free write controls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_reqReady <= 1'b1;
      r_memRdEn  <= 1'b0;
      r_memAddr  <= '0;
      r_dst      <= '0;
      r_dstM     <= NO_WRITE;
      r_valM     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_errCode  <= 2'b00;
      r_waitCnt  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_reqReady <= w_reqReady;
      r_memRdEn  <= w_memRdEn;
      r_memAddr  <= w_memAddr;
      r_dst      <= w_dst;
      r_dstM     <= w_dstM;
      r_valM     <= w_valM;
      r_done     <= w_done;
      r_err      <= w_err;
      r_errCode  <= w_errCode;
      r_waitCnt  <= w_waitCnt;
    end
  end

  // Next-state and next-output logic. Pulses (rd_en, done, err) and dstM default
  // to their idle values so that each is asserted for a single cycle only.
  always_comb begin
    w_stateNext = r_state;
    w_reqReady  = r_reqReady;
    w_memRdEn   = 1'b0;
    w_memAddr   = r_memAddr;
    w_dst       = r_dst;
    w_dstM      = NO_WRITE;
    w_valM      = r_valM;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_errCode   = r_errCode;
    w_waitCnt   = r_waitCnt;

    case (r_state)
      S_IDLE: begin
        if (!r_reqReady) begin
          // The cycle after any accept (including rejected ones) is a dead cycle.
          w_reqReady = 1'b1;
        end else if (i_req_valid) begin
          w_reqReady = 1'b0;
          w_dst      = i_req_dst;
          // Misalignment is checked first so it wins over a bad destination.
          if (i_req_addr[1:0] != 2'b00) begin
            w_err     = 1'b1;
            w_errCode = 2'b01;
          end else if (i_req_dst > 4'd5) begin
            w_err     = 1'b1;
            w_errCode = 2'b10;
          end else begin
            w_stateNext = S_ISSUE;
            w_memRdEn   = 1'b1;
            w_memAddr   = i_req_addr;
          end
        end
      end

      S_ISSUE: begin
        w_waitCnt   = '0;
        w_stateNext = S_WAIT;
      end

      S_WAIT: begin
        w_waitCnt = r_waitCnt + 8'd1;
        // A response arriving on the last allowed cycle still completes the load.
        if (i_mem_rvalid) begin
          w_valM      = i_mem_rdata;
          w_dstM      = r_dst;
          w_done      = 1'b1;
          w_stateNext = S_WRITE;
        end else if (r_waitCnt == WAIT_LAST) begin
          w_err       = 1'b1;
          w_errCode   = 2'b11;
          w_reqReady  = 1'b1;
          w_stateNext = S_IDLE;
        end
      end

      S_WRITE: begin
        w_reqReady  = 1'b1;
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
        w_reqReady  = 1'b1;
      end
    endcase
  end

  assign o_req_ready = r_reqReady;
  assign o_mem_rd_en = r_memRdEn;
  assign o_mem_addr  = r_memAddr;
  assign o_dstM      = r_dstM;
  assign o_valM      = r_valM;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_errCode;

endmodule
